// File: rtl/issue_pkg.sv
// Shared field widths, packet bit offsets and packet struct for the issue instruction FIFO.
package issue_pkg;

  localparam int PC_W       = 32;
  localparam int ROB_W      = 4;
  localparam int IMM_W      = 26;
  localparam int FID_W      = 8;
  localparam int ALU_CMD_W  = 5;
  localparam int MUL_CMD_W  = 1;
  localparam int MEM_CMD_W  = 5;
  localparam int BRU_CMD_W  = 7;
  localparam int BAGU_CMD_W = 2;

  localparam int PKT_W = PC_W + ROB_W + IMM_W + FID_W + 3 + 4 +
                         ALU_CMD_W + MUL_CMD_W + MEM_CMD_W + BRU_CMD_W + BAGU_CMD_W;

  // Offsets are counted from the LSB: bagu_cmd sits at the bottom, pc at the top.
  localparam int BAGU_OFF     = 0;
  localparam int BRUC_OFF     = BAGU_OFF + BAGU_CMD_W;
  localparam int MEMC_OFF     = BRUC_OFF + BRU_CMD_W;
  localparam int MULC_OFF     = MEMC_OFF + MEM_CMD_W;
  localparam int ALUC_OFF     = MULC_OFF + MUL_CMD_W;
  localparam int PIPE_BRU_OFF = ALUC_OFF + ALU_CMD_W;
  localparam int PIPE_MEM_OFF = PIPE_BRU_OFF + 1;
  localparam int PIPE_MUL_OFF = PIPE_MEM_OFF + 1;
  localparam int PIPE_ALU_OFF = PIPE_MUL_OFF + 1;
  localparam int STORE_OFF    = PIPE_ALU_OFF + 1;
  localparam int LOAD_OFF     = STORE_OFF + 1;
  localparam int BRANCH_OFF   = LOAD_OFF + 1;
  localparam int FID_OFF      = BRANCH_OFF + 1;
  localparam int IMM_OFF      = FID_OFF + FID_W;
  localparam int ROB_OFF      = IMM_OFF + IMM_W;
  localparam int PC_OFF       = ROB_OFF + ROB_W;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [ROB_W-1:0]      rob;
    logic [IMM_W-1:0]      imm;
    logic [FID_W-1:0]      fid;
    logic                  branch;
    logic                  load;
    logic                  store;
    logic                  pipe_alu;
    logic                  pipe_mul;
    logic                  pipe_mem;
    logic                  pipe_bru;
    logic [ALU_CMD_W-1:0]  alu_cmd;
    logic [MUL_CMD_W-1:0]  mul_cmd;
    logic [MEM_CMD_W-1:0]  mem_cmd;
    logic [BRU_CMD_W-1:0]  bru_cmd;
    logic [BAGU_CMD_W-1:0] bagu_cmd;
  } issue_pkt_t;

endpackage

// File: rtl/issue_inst_fifo_if.sv
// Upstream issue handshake, downstream dispatch handshake and occupancy status of the FIFO.
interface issue_inst_fifo_if
  import issue_pkg::*;
#(
  parameter int PTR_W = 2
) ();

  logic                  i_issue_valid;
  logic                  o_issue_ready;
  logic [PC_W-1:0]       i_issue_pc;
  logic [ROB_W-1:0]      i_issue_rob;
  logic [IMM_W-1:0]      i_issue_imm;
  logic [FID_W-1:0]      i_issue_fid;
  logic                  i_issue_branch;
  logic                  i_issue_load;
  logic                  i_issue_store;
  logic                  i_issue_pipe_alu;
  logic                  i_issue_pipe_mul;
  logic                  i_issue_pipe_mem;
  logic                  i_issue_pipe_bru;
  logic [ALU_CMD_W-1:0]  i_issue_alu_cmd;
  logic [MUL_CMD_W-1:0]  i_issue_mul_cmd;
  logic [MEM_CMD_W-1:0]  i_issue_mem_cmd;
  logic [BRU_CMD_W-1:0]  i_issue_bru_cmd;
  logic [BAGU_CMD_W-1:0] i_issue_bagu_cmd;

  logic                  o_disp_valid;
  logic                  i_disp_ready;
  logic [PC_W-1:0]       o_disp_pc;
  logic [ROB_W-1:0]      o_disp_rob;
  logic [IMM_W-1:0]      o_disp_imm;
  logic [FID_W-1:0]      o_disp_fid;
  logic                  o_disp_branch;
  logic                  o_disp_load;
  logic                  o_disp_store;
  logic                  o_disp_pipe_alu;
  logic                  o_disp_pipe_mul;
  logic                  o_disp_pipe_mem;
  logic                  o_disp_pipe_bru;
  logic [ALU_CMD_W-1:0]  o_disp_alu_cmd;
  logic [MUL_CMD_W-1:0]  o_disp_mul_cmd;
  logic [MEM_CMD_W-1:0]  o_disp_mem_cmd;
  logic [BRU_CMD_W-1:0]  o_disp_bru_cmd;
  logic [BAGU_CMD_W-1:0] o_disp_bagu_cmd;

  logic [PTR_W:0]        o_count;
  logic                  o_empty;
  logic                  o_full;

  modport slave (
    input  i_issue_valid, i_issue_pc, i_issue_rob, i_issue_imm, i_issue_fid,
           i_issue_branch, i_issue_load, i_issue_store, i_issue_pipe_alu,
           i_issue_pipe_mul, i_issue_pipe_mem, i_issue_pipe_bru, i_issue_alu_cmd,
           i_issue_mul_cmd, i_issue_mem_cmd, i_issue_bru_cmd, i_issue_bagu_cmd,
           i_disp_ready,
    output o_issue_ready, o_disp_valid, o_disp_pc, o_disp_rob, o_disp_imm, o_disp_fid,
           o_disp_branch, o_disp_load, o_disp_store, o_disp_pipe_alu, o_disp_pipe_mul,
           o_disp_pipe_mem, o_disp_pipe_bru, o_disp_alu_cmd, o_disp_mul_cmd,
           o_disp_mem_cmd, o_disp_bru_cmd, o_disp_bagu_cmd, o_count, o_empty, o_full
  );

  modport master (
    output i_issue_valid, i_issue_pc, i_issue_rob, i_issue_imm, i_issue_fid,
           i_issue_branch, i_issue_load, i_issue_store, i_issue_pipe_alu,
           i_issue_pipe_mul, i_issue_pipe_mem, i_issue_pipe_bru, i_issue_alu_cmd,
           i_issue_mul_cmd, i_issue_mem_cmd, i_issue_bru_cmd, i_issue_bagu_cmd,
           i_disp_ready,
    input  o_issue_ready, o_disp_valid, o_disp_pc, o_disp_rob, o_disp_imm, o_disp_fid,
           o_disp_branch, o_disp_load, o_disp_store, o_disp_pipe_alu, o_disp_pipe_mul,
           o_disp_pipe_mem, o_disp_pipe_bru, o_disp_alu_cmd, o_disp_mul_cmd,
           o_disp_mem_cmd, o_disp_bru_cmd, o_disp_bagu_cmd, o_count, o_empty, o_full
  );

endinterface

// File: rtl/issue_fifo_ctrl.sv
// Pointer, occupancy and handshake control for the issue FIFO.
// ISSUE_INST_FIFO_BYPASS_EN enables forwarding of an incoming packet to an empty head.
module issue_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             snoop_hit,
  input  logic             bco_valid,
  input  logic             issue_valid,
  input  logic             disp_ready,
  output logic             push,
  output logic             bypass_sel,
  output logic             issue_ready,
  output logic             disp_valid,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic flush;
  logic pop;

  assign flush       = snoop_hit | bco_valid;
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign issue_ready = ~full;

`ifdef ISSUE_INST_FIFO_BYPASS_EN
  assign bypass_sel = empty & issue_valid & ~flush;
`else
  assign bypass_sel = 1'b0;
`endif

  assign disp_valid = ~empty | bypass_sel;

  // A bypassed packet taken in the same cycle never occupies an entry.
  assign push = issue_valid & issue_ready & ~flush & ~(bypass_sel & disp_ready);
  assign pop  = ~empty & disp_ready & ~flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn) push |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!resetn) pop |-> !empty);
  a_count_range:  assert property (@(posedge clk) disable iff (!resetn) count <= FULL_CNT);

endmodule

// File: rtl/issue_inst_fifo.sv
// Issue instruction FIFO: in-order packet buffer between the decode issue register and dispatch.
// Define ISSUE_INST_FIFO_BYPASS_EN to forward an incoming packet straight to an empty head.
module issue_inst_fifo
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             snoop_hit,
  input  logic             bco_valid,
  issue_inst_fifo_if.slave bus
);

  logic             push;
  logic             bypass_sel;
  logic             issue_ready;
  logic             disp_valid;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PKT_W-1:0] pkt_in;
  logic [PKT_W-1:0] head_pkt;
  logic [PKT_W-1:0] disp_pkt;
  logic [PKT_W-1:0] mem [DEPTH];

  issue_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
    .clk         (clk),
    .resetn      (resetn),
    .snoop_hit   (snoop_hit),
    .bco_valid   (bco_valid),
    .issue_valid (bus.i_issue_valid),
    .disp_ready  (bus.i_disp_ready),
    .push        (push),
    .bypass_sel  (bypass_sel),
    .issue_ready (issue_ready),
    .disp_valid  (disp_valid),
    .empty       (empty),
    .full        (full),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  always_comb begin
    pkt_in = '0;
    pkt_in[PC_OFF +: PC_W]             = bus.i_issue_pc;
    pkt_in[ROB_OFF +: ROB_W]           = bus.i_issue_rob;
    pkt_in[IMM_OFF +: IMM_W]           = bus.i_issue_imm;
    pkt_in[FID_OFF +: FID_W]           = bus.i_issue_fid;
    pkt_in[BRANCH_OFF]                 = bus.i_issue_branch;
    pkt_in[LOAD_OFF]                   = bus.i_issue_load;
    pkt_in[STORE_OFF]                  = bus.i_issue_store;
    pkt_in[PIPE_ALU_OFF]               = bus.i_issue_pipe_alu;
    pkt_in[PIPE_MUL_OFF]               = bus.i_issue_pipe_mul;
    pkt_in[PIPE_MEM_OFF]               = bus.i_issue_pipe_mem;
    pkt_in[PIPE_BRU_OFF]               = bus.i_issue_pipe_bru;
    pkt_in[ALUC_OFF +: ALU_CMD_W]      = bus.i_issue_alu_cmd;
    pkt_in[MULC_OFF +: MUL_CMD_W]      = bus.i_issue_mul_cmd;
    pkt_in[MEMC_OFF +: MEM_CMD_W]      = bus.i_issue_mem_cmd;
    pkt_in[BRUC_OFF +: BRU_CMD_W]      = bus.i_issue_bru_cmd;
    pkt_in[BAGU_OFF +: BAGU_CMD_W]     = bus.i_issue_bagu_cmd;
  end

  // Payload storage is intentionally unreset; the head is only meaningful while valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_in;
  end

  assign head_pkt = mem[rd_ptr];
  assign disp_pkt = bypass_sel ? pkt_in : head_pkt;

  assign bus.o_issue_ready    = issue_ready;
  assign bus.o_disp_valid     = disp_valid;
  assign bus.o_count          = count;
  assign bus.o_empty          = empty;
  assign bus.o_full           = full;
  assign bus.o_disp_pc        = disp_pkt[PC_OFF +: PC_W];
  assign bus.o_disp_rob       = disp_pkt[ROB_OFF +: ROB_W];
  assign bus.o_disp_imm       = disp_pkt[IMM_OFF +: IMM_W];
  assign bus.o_disp_fid       = disp_pkt[FID_OFF +: FID_W];
  assign bus.o_disp_branch    = disp_pkt[BRANCH_OFF];
  assign bus.o_disp_load      = disp_pkt[LOAD_OFF];
  assign bus.o_disp_store     = disp_pkt[STORE_OFF];
  assign bus.o_disp_pipe_alu  = disp_pkt[PIPE_ALU_OFF];
  assign bus.o_disp_pipe_mul  = disp_pkt[PIPE_MUL_OFF];
  assign bus.o_disp_pipe_mem  = disp_pkt[PIPE_MEM_OFF];
  assign bus.o_disp_pipe_bru  = disp_pkt[PIPE_BRU_OFF];
  assign bus.o_disp_alu_cmd   = disp_pkt[ALUC_OFF +: ALU_CMD_W];
  assign bus.o_disp_mul_cmd   = disp_pkt[MULC_OFF +: MUL_CMD_W];
  assign bus.o_disp_mem_cmd   = disp_pkt[MEMC_OFF +: MEM_CMD_W];
  assign bus.o_disp_bru_cmd   = disp_pkt[BRUC_OFF +: BRU_CMD_W];
  assign bus.o_disp_bagu_cmd  = disp_pkt[BAGU_OFF +: BAGU_CMD_W];

  a_pipe_onehot: assert property (@(posedge clk) disable iff (!resetn)
    push |-> ($countones({bus.i_issue_pipe_alu, bus.i_issue_pipe_mul,
                          bus.i_issue_pipe_mem, bus.i_issue_pipe_bru}) <= 1));

endmodule

// File: tb/tb_issue_inst_fifo.sv
// Randomized and directed bench for issue_inst_fifo against a queue-based reference model.
module tb_issue_inst_fifo;
  import issue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic snoop_hit = 1'b0;
  logic bco_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  issue_pkt_t model_q[$];

  issue_inst_fifo_if #(.PTR_W(2)) bus ();

  issue_inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .snoop_hit (snoop_hit),
    .bco_valid (bco_valid),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic issue_pkt_t make_pkt(input logic [31:0] pc);
    issue_pkt_t p;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    p = r[PKT_W-1:0];
    p.pc = pc;
    {p.pipe_alu, p.pipe_mul, p.pipe_mem, p.pipe_bru} = 4'b0000;
    case ($urandom_range(0, 4))
      0: p.pipe_alu = 1'b1;
      1: p.pipe_mul = 1'b1;
      2: p.pipe_mem = 1'b1;
      3: p.pipe_bru = 1'b1;
      default: ;
    endcase
    return p;
  endfunction

  function automatic issue_pkt_t observed_head();
    issue_pkt_t o;
    o.pc = bus.o_disp_pc;             o.rob = bus.o_disp_rob;
    o.imm = bus.o_disp_imm;           o.fid = bus.o_disp_fid;
    o.branch = bus.o_disp_branch;     o.load = bus.o_disp_load;
    o.store = bus.o_disp_store;       o.pipe_alu = bus.o_disp_pipe_alu;
    o.pipe_mul = bus.o_disp_pipe_mul; o.pipe_mem = bus.o_disp_pipe_mem;
    o.pipe_bru = bus.o_disp_pipe_bru; o.alu_cmd = bus.o_disp_alu_cmd;
    o.mul_cmd = bus.o_disp_mul_cmd;   o.mem_cmd = bus.o_disp_mem_cmd;
    o.bru_cmd = bus.o_disp_bru_cmd;   o.bagu_cmd = bus.o_disp_bagu_cmd;
    return o;
  endfunction

  task automatic drive_pkt(input issue_pkt_t p);
    bus.i_issue_pc = p.pc;             bus.i_issue_rob = p.rob;
    bus.i_issue_imm = p.imm;           bus.i_issue_fid = p.fid;
    bus.i_issue_branch = p.branch;     bus.i_issue_load = p.load;
    bus.i_issue_store = p.store;       bus.i_issue_pipe_alu = p.pipe_alu;
    bus.i_issue_pipe_mul = p.pipe_mul; bus.i_issue_pipe_mem = p.pipe_mem;
    bus.i_issue_pipe_bru = p.pipe_bru; bus.i_issue_alu_cmd = p.alu_cmd;
    bus.i_issue_mul_cmd = p.mul_cmd;   bus.i_issue_mem_cmd = p.mem_cmd;
    bus.i_issue_bru_cmd = p.bru_cmd;   bus.i_issue_bagu_cmd = p.bagu_cmd;
  endtask

  // One clock of stimulus: drive, check the model's view of the outputs, then advance the model.
  task automatic apply_stimulus(input logic valid, input issue_pkt_t p, input logic dready,
                                input logic snoop, input logic bco);
    logic flush, exp_ready, exp_valid, byp, do_push, do_pop;
    issue_pkt_t exp_head;
    @(negedge clk);
    bus.i_issue_valid = valid;
    bus.i_disp_ready  = dready;
    snoop_hit = snoop;
    bco_valid = bco;
    drive_pkt(p);
    #1;
    flush     = snoop | bco;
    exp_ready = model_q.size() < DEPTH;
    byp       = 1'b0;
`ifdef ISSUE_INST_FIFO_BYPASS_EN
    byp = (model_q.size() == 0) && valid && !flush;
`endif
    exp_valid = (model_q.size() > 0) || byp;
    check_output("disp_valid", bus.o_disp_valid, exp_valid);
    check_output("issue_ready", bus.o_issue_ready, exp_ready);
    check_output("count", bus.o_count, model_q.size());
    check_output("empty", bus.o_empty, model_q.size() == 0);
    check_output("full", bus.o_full, model_q.size() == DEPTH);
    if (exp_valid) begin
      exp_head = byp ? p : model_q[0];
      check_output("head_pkt", observed_head(), exp_head);
    end
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() > 0) && dready;
      do_push = valid && exp_ready && !(byp && dready);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(p);
    end
  endtask

  task automatic idle(input logic dready);
    apply_stimulus(1'b0, make_pkt($urandom), dready, 1'b0, 1'b0);
  endtask

  initial begin
    issue_pkt_t p;
    bus.i_issue_valid = 1'b0;
    bus.i_disp_ready  = 1'b0;
    drive_pkt(make_pkt(32'h0));
    repeat (2) @(negedge clk);
    check_output("rst_valid", bus.o_disp_valid, 1'b0);
    check_output("rst_ready", bus.o_issue_ready, 1'b1);
    resetn = 1'b1;

    // Fill to full; a fifth push is refused.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, make_pkt(32'h100 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    check_output("full_head_pc", bus.o_disp_pc, 32'h100);
    apply_stimulus(1'b1, make_pkt(32'h110), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Steady stream with one packet resident.
    apply_stimulus(1'b1, make_pkt(32'h300), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, make_pkt(32'h304 + 32'(4 * i)), 1'b1, 1'b0, 1'b0);
    check_output("stream_count", bus.o_count, 3'd1);
    idle(1'b1);
    idle(1'b0);

    // Flush by branch correction, then by snoop, each with push and pop pending.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, make_pkt(32'h400 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, make_pkt(32'hDEAD), 1'b1, f == 1, f == 0);
      idle(1'b0);
      idle(1'b1);
    end

    // Asynchronous reset while two packets are held.
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1, make_pkt(32'h500 + 32'(4 * i)), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_issue_valid = 1'b0;
    bus.i_disp_ready  = 1'b0;
    resetn = 1'b0;
    #1;
    check_output("arst_valid", bus.o_disp_valid, 1'b0);
    check_output("arst_empty", bus.o_empty, 1'b1);
    check_output("arst_count", bus.o_count, 3'd0);
    check_output("arst_ready", bus.o_issue_ready, 1'b1);
    check_output("arst_full", bus.o_full, 1'b0);
    model_q.delete();
    #1 resetn = 1'b1;

    // Single packet into an empty FIFO with dispatch ready.
    apply_stimulus(1'b1, make_pkt(32'h200), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      p = make_pkt($urandom);
      apply_stimulus($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) < 6,
                     $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
    end
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_inst_fifo.md
Name: issue_inst_fifo

Overview:
- Decoupling buffer directly downstream of the decode issue-register stage.
- Accepts one decoded issue packet per cycle: pc, rob, imm, fid, class flags, pipe selects and per-pipe cmds.
- Holds packets in a small circular FIFO and presents them in order to the issue/dispatch stage under a valid/ready handshake.
- Flushes all contents on snoop hit or branch-correction (bco).

Parameters:
- DEPTH, 4, number of packet entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); read/write pointer width.
- PKT_W, 97, packet width: pc32 + rob4 + imm26 + fid8 + branch/load/store 3 + pipe alu/mul/mem/bru 4 + alu_cmd5 + mul_cmd1 + mem_cmd5 + bru_cmd7 + bagu_cmd2.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- snoop_hit  in  1  flush request.
- bco_valid  in  1  branch-correction flush request.
- i_issue_valid  in  1  upstream packet valid.
- o_issue_ready  out  1  space available; equals ~full.
- i_issue_pc/rob/imm/fid/branch/load/store/pipe_alu/pipe_mul/pipe_mem/pipe_bru/alu_cmd/mul_cmd/mem_cmd/bru_cmd/bagu_cmd  in  per-field widths above  upstream packet fields.
- o_disp_valid  out  1  head entry valid.
- i_disp_ready  in  1  downstream accepts head.
- o_disp_*  out  same field set and widths as input  head packet fields.
- o_count  out  PTR_W+1  occupancy.
- o_empty  out  1  count==0.
- o_full  out  1  count==DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset state: wr_ptr=0, rd_ptr=0, count=0. Resulting outputs: o_disp_valid=0, o_empty=1, o_full=0, o_issue_ready=1, o_count=0.
- Payload storage has no reset. o_disp_* fields are don't-care while o_disp_valid=0.
- Push: push = i_issue_valid & o_issue_ready & ~flush, where flush = snoop_hit | bco_valid.
  - Writes the packet to mem[wr_ptr].
  - wr_ptr increments mod DEPTH.
- Pop: pop = o_disp_valid & i_disp_ready & ~flush.
  - rd_ptr increments mod DEPTH.
- Count update: count +1 on push only, -1 on pop only, unchanged on push and pop together.
- Ready: o_issue_ready = ~full, registered from count. There is no enqueue-when-full even if a pop occurs the same cycle; upstream sees ready deassert for at least one cycle.
- Output: o_disp_valid = ~empty. o_disp_* = mem[rd_ptr], read combinationally.
- Latency: push at edge N makes the packet visible at the head after edge N (1 cycle) when the FIFO was empty.
- Flush: snoop_hit or bco_valid high at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - The input packet in that cycle is dropped.
  - Any pop that cycle is not counted as consumed; downstream must also qualify on flush.
  - Flush has priority over push and pop.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, never by pointer equality.
- Ordering: strict FIFO. No reordering by pipe. Pipe-select bits pass through unmodified.
- Reset mid-operation: asynchronous clear to the reset state regardless of in-flight handshakes.
- Assertions:
  - no push when full;
  - no pop when empty;
  - count <= DEPTH;
  - at most one of pipe_alu/mul/mem/bru set on a valid push.

Optional Feature:
- Macro: ISSUE_INST_FIFO_BYPASS_EN.
- When defined: if empty & i_issue_valid & ~flush, then o_disp_valid=1 and o_disp_* are driven combinationally from i_issue_*.
  - If i_disp_ready is also high, the packet is consumed without being written (0-cycle latency) and count stays 0.
  - Otherwise it is written normally.
- When undefined: no bypass. Minimum latency is 1 cycle, and outputs depend only on registered state.

Decomposition:
- Shared package (issue_pkg):
  - field width constants: PC_W=32, ROB_W=4, IMM_W=26, FID_W=8, ALU_CMD_W=5, MUL_CMD_W=1, MEM_CMD_W=5, BRU_CMD_W=7, BAGU_CMD_W=2;
  - PKT_W derived from them;
  - pack/unpack field offset constants.
- Sub-module: issue_fifo_ctrl, holding pointers, count, full/empty, push/pop/flush qualification and bypass select. The top level holds the payload array and the field pack/unpack.

Test Plan:
- Reset then 4 pushes (pc=0x100, 0x104, 0x108, 0x10C) with i_disp_ready=0:
  - o_full=1, o_issue_ready=0, o_count=4;
  - a 5th push attempt is ignored;
  - head pc=0x100.
- Full FIFO, i_disp_ready=1 for 4 cycles, i_issue_valid=0:
  - pcs 0x100..0x10C emerge in order;
  - then o_empty=1, o_disp_valid=0.
- Steady stream, push and pop every cycle for 10 cycles:
  - count stays 1;
  - pointers wrap twice;
  - output pc sequence equals the input sequence delayed by 1.
- Count=3 then bco_valid=1 with a simultaneous push and pop:
  - next cycle count=0, o_disp_valid=0;
  - the pushed packet never appears.
  - Repeat with snoop_hit: same result.
- resetn low asynchronously mid-stream at count=2:
  - outputs go to reset values immediately, before the next clk edge.
- With ISSUE_INST_FIFO_BYPASS_EN, empty FIFO, i_issue_valid=1, pc=0x200, i_disp_ready=1:
  - o_disp_valid=1 and o_disp_pc=0x200 in the same cycle;
  - count remains 0.
  - Without the macro: the packet appears on the next cycle.
